jtkiwi_gfxrom_arb: RTL and testbench
====================================

// Module: jtkiwi_gfxrom_arb
// PURPOSE
// - Downstream of the video block's ROM fetch ports: serves scr_* and obj_* 32-bit tile/sprite reads from one SDRAM port.
// - One-entry cache per channel; round-robin arbitration on misses.
// - Sits between the video block and the SDRAM controller inside the game top.
// PARAMETERS
// - SCR_OFFSET  22'h00_0000  SDRAM 16-bit word base of the scroll ROM region
// - OBJ_OFFSET  22'h10_0000  SDRAM 16-bit word base of the object ROM region
// PORTS
// - rst         in   1   reset, synchronous, active-high
// - clk         in   1   single clock; all logic on posedge clk
// - scr_addr    in   18  scroll ROM 32-bit word address [19:2]
// - scr_cs      in   1   scroll read request, level
// - scr_data    out  32  scroll data, valid while scr_ok
// - scr_ok      out  1   scr_data matches current scr_addr
// - obj_addr    in   18  object ROM 32-bit word address [19:2]
// - obj_cs      in   1   object read request, level
// - obj_data    out  32  object data, valid while obj_ok
// - obj_ok      out  1   obj_data matches current obj_addr
// - sdram_addr  out  22  SDRAM 16-bit word address
// - sdram_req   out  1   request, held until sdram_ack
// - sdram_ack   in   1   one-cycle pulse: request accepted
// - sdram_rdy   in   1   one-cycle pulse: sdram_din valid
// - sdram_din   in   32  read data
// - debug_bus   in   8   statistics byte select
// - st_dout     out  8   statistics output
// BEHAVIOUR
// - Reset: valid bits, tags and data 0; state IDLE; sdram_req 0; sdram_addr 0; *_ok 0; st_dout 0.
// - Per channel: hit = cs & valid & (tag == addr); ok = hit (combinational from registers); data = cached word.
// - Miss = cs & ~hit. FSM: IDLE -> REQ when any miss; REQ -> WAIT on sdram_ack; WAIT -> IDLE on sdram_rdy.
// - IDLE grant: single miss wins; both miss -> channel not served last (last_gnt toggles per grant; reset value obj, so scr wins first tie).
// - On grant: latch channel and tag = addr; sdram_addr = {tag,1'b0} + OFFSET, modulo 2^22; sdram_req=1 next cycle.
// - sdram_req drops the cycle after sdram_ack. ack and rdy in the same cycle: FSM accepts both, goes IDLE.
// - On sdram_rdy: served channel data <= sdram_din, tag <= latched tag, valid <= 1; ok visible next cycle if addr still matches.
// - Latency, idle bus: cs/miss at cycle N -> req at N+1; rdy at cycle M -> ok at M+1.
// - cs dropped or addr changed mid-request: transaction completes, cache fills with latched tag; new address misses and is issued from IDLE.
// - rdy outside WAIT is ignored. New miss on the rdy cycle is arbitrated next cycle, from IDLE.
// - Reset mid-transaction: rst aborts immediately, cache invalidated; a late sdram_rdy is ignored.
// CONFIGURATION
// - JTKIWI_ARB_STATS_EN defined: per-channel 16-bit miss counters.
//   - Counter +1 per grant; saturates at 16'hFFFF; cleared only by rst.
//   - st_dout byte by debug_bus[1:0]: 0 scr[7:0], 1 scr[15:8], 2 obj[7:0], 3 obj[15:8].
// - Undefined: no counters; st_dout tied to 8'd0.
// STRUCTURE
// - Package jtkiwi_arb_pkg: FSM state enum (IDLE, REQ, WAIT); channel index constants CH_SCR=0, CH_OBJ=1; ROM_AW=18, SD_AW=22 widths.
// - Sub-module jtkiwi_arb_slot, instantiated twice:
//   - Holds tag, valid and data; produces hit and miss.
//   - Fill port: we, tag, data.
// - Top holds the FSM, the round-robin state and the optional counters.
// TESTING
// - Reset, then scr_cs=1 scr_addr=18'h00010 -> sdram_addr=22'h000020 and sdram_req at +1; ack, rdy with 32'hDEADBEEF -> scr_ok=1 and scr_data=DEADBEEF next cycle.
// - Repeat scr_addr=18'h00010 -> scr_ok=1 with no sdram_req; change to 18'h00011 -> scr_ok=0 the same cycle, then a new request.
// - Both channels miss (scr 18'h00004, obj 18'h00008) -> scr served first; obj then served with sdram_addr=22'h100010.
// - Both miss again -> obj served first (round-robin).
// - obj addr changes mid-WAIT -> old tag filled; obj_ok stays 0; new request issued after rdy.
// - Ack and rdy in the same cycle -> fill occurs and FSM is IDLE next cycle.
// - rst asserted in WAIT -> req=0, ok=0; stray rdy next cycle leaves all valid bits 0.
// - With JTKIWI_ARB_STATS_EN: 3 scr misses, debug_bus=0 -> st_dout=8'd3; debug_bus=2 -> 8'd0.
// - Without JTKIWI_ARB_STATS_EN: st_dout=8'd0 for every debug_bus value.

Source files
------------

// File: rtl/jtkiwi_arb_pkg.sv
// Shared types and widths for the gfx ROM arbiter: FSM states, channel indices
// and the ROM-word to SDRAM-word address mapping.
package jtkiwi_arb_pkg;
   localparam int ROM_AW = 18;
   localparam int SD_AW  = 22;

   localparam logic CH_SCR = 1'b0;
   localparam logic CH_OBJ = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } arb_state_t;

   // A 32-bit ROM word spans two 16-bit SDRAM words; the sum wraps at 2^22.
   function automatic logic [SD_AW-1:0] rom2sd(input logic [ROM_AW-1:0] tag,
                                               input logic [SD_AW-1:0]  offset);
      logic [SD_AW-1:0] word_s;
      word_s = {3'b000, tag, 1'b0};
      return word_s + offset;
   endfunction
endpackage

// File: rtl/jtkiwi_arb_slot.sv
// One-entry read cache for a single ROM channel: tag, valid bit and data word,
// with hit/miss decode against the live request address.
module jtkiwi_arb_slot
   import jtkiwi_arb_pkg::*;
(
   input  logic              rst,
   input  logic              clk,
   input  logic              cs,
   input  logic [ROM_AW-1:0] addr,
   input  logic              we,
   input  logic [ROM_AW-1:0] fill_tag,
   input  logic [31:0]       fill_data,
   output logic              hit,
   output logic              miss,
   output logic [31:0]       data
);
   logic [ROM_AW-1:0] tag_r;
   logic              valid_r;
   logic [31:0]       data_r;

   // Cache entry update: cleared by reset, overwritten on every fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_r   <= {ROM_AW{1'b0}};
         valid_r <= 1'b0;
         data_r  <= 32'd0;
      end else if (we) begin
         tag_r   <= fill_tag;
         valid_r <= 1'b1;
         data_r  <= fill_data;
      end else begin
         tag_r   <= tag_r;
         valid_r <= valid_r;
         data_r  <= data_r;
      end
   end

   assign hit  = cs & valid_r & (tag_r == addr);
   assign miss = cs & ~hit;
   assign data = data_r;
endmodule

// File: rtl/jtkiwi_gfxrom_arb.sv
// Two-channel (scroll/object) ROM read arbiter onto a single SDRAM port with a
// one-entry cache per channel. Define JTKIWI_ARB_STATS_EN for miss counters.
module jtkiwi_gfxrom_arb
   import jtkiwi_arb_pkg::*;
#(
   parameter logic [SD_AW-1:0] SCR_OFFSET = 22'h00_0000,
   parameter logic [SD_AW-1:0] OBJ_OFFSET = 22'h10_0000
)(
   input  logic              rst,
   input  logic              clk,
   input  logic [ROM_AW-1:0] scr_addr,
   input  logic              scr_cs,
   output logic [31:0]       scr_data,
   output logic              scr_ok,
   input  logic [ROM_AW-1:0] obj_addr,
   input  logic              obj_cs,
   output logic [31:0]       obj_data,
   output logic              obj_ok,
   output logic [SD_AW-1:0]  sdram_addr,
   output logic              sdram_req,
   input  logic              sdram_ack,
   input  logic              sdram_rdy,
   input  logic [31:0]       sdram_din,
   input  logic [7:0]        debug_bus,
   output logic [7:0]        st_dout
);
   arb_state_t        state_r;
   logic              ch_r;
   logic              last_gnt_r;
   logic [ROM_AW-1:0] tag_r;
   logic [SD_AW-1:0]  sdram_addr_r;
   logic              sdram_req_r;

   logic              scr_hit_s, scr_miss_s, obj_hit_s, obj_miss_s;
   logic              grant_s, gnt_s, fill_s;
   logic [ROM_AW-1:0] gnt_tag_s;
   logic [SD_AW-1:0]  gnt_addr_s;

   jtkiwi_arb_slot u_scr (
      .rst      (rst),
      .clk      (clk),
      .cs       (scr_cs),
      .addr     (scr_addr),
      .we       (fill_s & (ch_r == CH_SCR)),
      .fill_tag (tag_r),
      .fill_data(sdram_din),
      .hit      (scr_hit_s),
      .miss     (scr_miss_s),
      .data     (scr_data)
   );

   jtkiwi_arb_slot u_obj (
      .rst      (rst),
      .clk      (clk),
      .cs       (obj_cs),
      .addr     (obj_addr),
      .we       (fill_s & (ch_r == CH_OBJ)),
      .fill_tag (tag_r),
      .fill_data(sdram_din),
      .hit      (obj_hit_s),
      .miss     (obj_miss_s),
      .data     (obj_data)
   );

   // Round-robin pick: on a tie the channel not served last goes first.
   always_comb begin
      gnt_s      = CH_SCR;
      gnt_tag_s  = scr_addr;
      gnt_addr_s = rom2sd(scr_addr, SCR_OFFSET);
      grant_s    = (state_r == IDLE) & (scr_miss_s | obj_miss_s);
      if (scr_miss_s && (!obj_miss_s || last_gnt_r == CH_OBJ)) begin
         gnt_s = CH_SCR;
      end else begin
         gnt_s      = CH_OBJ;
         gnt_tag_s  = obj_addr;
         gnt_addr_s = rom2sd(obj_addr, OBJ_OFFSET);
      end
   end

   // rdy only counts once the request has been accepted (same-cycle ack allowed).
   assign fill_s = sdram_rdy & ((state_r == WAIT) | ((state_r == REQ) & sdram_ack));

   // Request sequencer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         ch_r         <= CH_SCR;
         last_gnt_r   <= CH_OBJ;
         tag_r        <= {ROM_AW{1'b0}};
         sdram_addr_r <= {SD_AW{1'b0}};
         sdram_req_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (grant_s) begin
                  ch_r         <= gnt_s;
                  last_gnt_r   <= gnt_s;
                  tag_r        <= gnt_tag_s;
                  sdram_addr_r <= gnt_addr_s;
                  sdram_req_r  <= 1'b1;
                  state_r      <= REQ;
               end
            end
            REQ: begin
               if (sdram_ack) begin
                  sdram_req_r <= 1'b0;
                  state_r     <= sdram_rdy ? IDLE : WAIT;
               end
            end
            WAIT: begin
               if (sdram_rdy) state_r <= IDLE;
            end
            default: begin
               sdram_req_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign sdram_addr = sdram_addr_r;
   assign sdram_req  = sdram_req_r;
   assign scr_ok     = scr_hit_s;
   assign obj_ok     = obj_hit_s;

`ifdef JTKIWI_ARB_STATS_EN
   logic [15:0] scr_cnt_r, obj_cnt_r;
   logic [7:0]  st_r;
   logic        unused_s;

   assign unused_s = ^debug_bus[7:2];

   // Saturating per-channel grant counters and the byte-select readout.
   always_ff @(posedge clk) begin
      if (rst) begin
         scr_cnt_r <= 16'd0;
         obj_cnt_r <= 16'd0;
         st_r      <= 8'd0;
      end else begin
         if (grant_s && gnt_s == CH_SCR && scr_cnt_r != 16'hFFFF) scr_cnt_r <= scr_cnt_r + 16'd1;
         if (grant_s && gnt_s == CH_OBJ && obj_cnt_r != 16'hFFFF) obj_cnt_r <= obj_cnt_r + 16'd1;
         case (debug_bus[1:0])
            2'd0:    st_r <= scr_cnt_r[7:0];
            2'd1:    st_r <= scr_cnt_r[15:8];
            2'd2:    st_r <= obj_cnt_r[7:0];
            2'd3:    st_r <= obj_cnt_r[15:8];
            default: st_r <= 8'd0;
         endcase
      end
   end

   assign st_dout = st_r;
`else
   logic unused_s;

   assign unused_s = ^debug_bus;
   assign st_dout  = 8'd0;
`endif
endmodule

// File: tb/tb_jtkiwi_gfxrom_arb.sv
// Bench for jtkiwi_gfxrom_arb: vector table, corner sequences, then random
// traffic against a transaction-level cache/arbiter model.
module tb_jtkiwi_gfxrom_arb;
   localparam logic [21:0] SCR_OFF = 22'h00_0000;
   localparam logic [21:0] OBJ_OFF = 22'h10_0000;

   logic        clk, rst;
   logic [17:0] scr_addr, obj_addr;
   logic        scr_cs, obj_cs, scr_ok, obj_ok;
   logic [31:0] scr_data, obj_data, din;
   logic [21:0] sdram_addr;
   logic        sdram_req, ack, rdy;
   logic [7:0]  debug_bus, st_dout;

   int n_chk  = 0;
   int n_pass = 0;

   jtkiwi_gfxrom_arb dut (
      .rst(rst), .clk(clk),
      .scr_addr(scr_addr), .scr_cs(scr_cs), .scr_data(scr_data), .scr_ok(scr_ok),
      .obj_addr(obj_addr), .obj_cs(obj_cs), .obj_data(obj_data), .obj_ok(obj_ok),
      .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(ack),
      .sdram_rdy(rdy), .sdram_din(din), .debug_bus(debug_bus), .st_dout(st_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        cs;
      logic [17:0] addr;
      logic        ack;
      logic        rdy;
      logic [31:0] din;
      logic        e_req;
      logic [21:0] e_addr;
      logic        e_ok;
      logic [31:0] e_data;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      ack = 1'b0;
      rdy = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; scr_cs = 1'b0; obj_cs = 1'b0; ack = 1'b0; rdy = 1'b0;
      scr_addr = 18'd0; obj_addr = 18'd0; din = 32'd0; debug_bus = 8'd0;
      cyc(); cyc();
      rst = 1'b0;
   endtask

   // Memory contents seen by the bench's SDRAM responder.
   function automatic logic [31:0] mem(input logic [21:0] a);
      return {a[9:0], a} ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic [21:0] sd(input logic [17:0] t, input logic [21:0] off);
      int unsigned v;
      v = 32'(t) * 32'd2 + 32'(off);
      return 22'(v % 32'h0040_0000);
   endfunction

   // model state for the random phase
   logic        mv[2];
   logic [17:0] mt[2];
   int          ph;
   logic        mch, mlast;
   logic [17:0] mtag;
   int          mcnt[2];
   logic [21:0] sd_lat;

   task automatic model_fill();
      mv[mch] = 1'b1;
      mt[mch] = mtag;
      ph      = 0;
   endtask

   initial begin
      logic e_ok0, e_ok1, m0, m1, g;
      logic [7:0] e_st;

      tbl[0]  = '{1'b1, 18'h10, 1'b0, 1'b0, 32'h0,         1'b0, 22'h0,  1'b0, 32'h0};
      tbl[1]  = '{1'b1, 18'h10, 1'b1, 1'b0, 32'h0,         1'b1, 22'h20, 1'b0, 32'h0};
      tbl[2]  = '{1'b1, 18'h10, 1'b0, 1'b1, 32'hDEADBEEF,  1'b0, 22'h0,  1'b0, 32'h0};
      tbl[3]  = '{1'b1, 18'h10, 1'b0, 1'b0, 32'h0,         1'b0, 22'h0,  1'b1, 32'hDEADBEEF};
      tbl[4]  = '{1'b1, 18'h10, 1'b0, 1'b0, 32'h0,         1'b0, 22'h0,  1'b1, 32'hDEADBEEF};
      tbl[5]  = '{1'b1, 18'h11, 1'b0, 1'b0, 32'h0,         1'b0, 22'h0,  1'b0, 32'h0};
      tbl[6]  = '{1'b1, 18'h11, 1'b1, 1'b1, 32'h12345678,  1'b1, 22'h22, 1'b0, 32'h0};
      tbl[7]  = '{1'b1, 18'h11, 1'b0, 1'b0, 32'h0,         1'b0, 22'h0,  1'b1, 32'h12345678};
      tbl[8]  = '{1'b1, 18'h12, 1'b0, 1'b0, 32'h0,         1'b0, 22'h0,  1'b0, 32'h0};
      tbl[9]  = '{1'b1, 18'h12, 1'b1, 1'b0, 32'h0,         1'b1, 22'h24, 1'b0, 32'h0};
      tbl[10] = '{1'b1, 18'h12, 1'b0, 1'b1, 32'hCAFEF00D,  1'b0, 22'h0,  1'b0, 32'h0};
      tbl[11] = '{1'b1, 18'h12, 1'b0, 1'b0, 32'h0,         1'b0, 22'h0,  1'b1, 32'hCAFEF00D};

      // reset state
      do_reset();
      scr_cs = 1'b1; scr_addr = 18'h10; #1;
      chk("rst_req", 32'(sdram_req), 32'd0);
      chk("rst_addr", 32'(sdram_addr), 32'd0);
      chk("rst_scr_ok", 32'(scr_ok), 32'd0);
      chk("rst_obj_ok", 32'(obj_ok), 32'd0);
      chk("rst_scr_data", scr_data, 32'd0);
      chk("rst_obj_data", obj_data, 32'd0);
      chk("rst_st", 32'(st_dout), 32'd0);

      // vector table: scr miss/hit/re-miss, ack+rdy same cycle, back-to-back
      do_reset();
      for (int i = 0; i < 12; i++) begin
         scr_cs = tbl[i].cs; scr_addr = tbl[i].addr;
         ack = tbl[i].ack; rdy = tbl[i].rdy; din = tbl[i].din;
         #1;
         chk($sformatf("tbl%0d_req", i), 32'(sdram_req), 32'(tbl[i].e_req));
         if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), 32'(sdram_addr), 32'(tbl[i].e_addr));
         chk($sformatf("tbl%0d_ok", i), 32'(scr_ok), 32'(tbl[i].e_ok));
         if (tbl[i].e_ok) chk($sformatf("tbl%0d_data", i), scr_data, tbl[i].e_data);
         chk($sformatf("tbl%0d_obj_ok", i), 32'(obj_ok), 32'd0);
         cyc();
      end

      // tie: scr first, then obj (round-robin), scr moves mid-transaction
      do_reset();
      scr_cs = 1'b1; scr_addr = 18'h4; obj_cs = 1'b1; obj_addr = 18'h8; #1;
      chk("tie_idle_req", 32'(sdram_req), 32'd0);
      cyc(); #1;
      chk("tie_scr_req", 32'(sdram_req), 32'd1);
      chk("tie_scr_addr", 32'(sdram_addr), 32'h000008);
      ack = 1'b1; cyc();
      rdy = 1'b1; din = 32'hA0A0A0A0; scr_addr = 18'h5; #1;
      chk("tie_scr_moved_ok", 32'(scr_ok), 32'd0);
      cyc(); #1;
      chk("scr_stale_fill_ok", 32'(scr_ok), 32'd0);
      cyc(); #1;
      chk("rr_obj_req", 32'(sdram_req), 32'd1);
      chk("rr_obj_addr", 32'(sdram_addr), 32'h100010);
      ack = 1'b1; rdy = 1'b1; din = 32'hB0B0B0B0; cyc(); #1;
      chk("rr_obj_ok", 32'(obj_ok), 32'd1);
      chk("rr_obj_data", obj_data, 32'hB0B0B0B0);
      chk("rr_idle_req", 32'(sdram_req), 32'd0);
      cyc(); #1;
      chk("rr_scr_req", 32'(sdram_req), 32'd1);
      chk("rr_scr_addr", 32'(sdram_addr), 32'h00000A);
      ack = 1'b1; cyc(); rdy = 1'b1; din = 32'hC0C0C0C0; cyc(); #1;
      chk("rr_scr_ok", 32'(scr_ok), 32'd1);
      chk("rr_scr_data", scr_data, 32'hC0C0C0C0);
      chk("rr_obj_still_ok", 32'(obj_ok), 32'd1);

      // obj address changes while waiting for data
      do_reset();
      obj_cs = 1'b1; obj_addr = 18'h20;
      cyc(); #1;
      chk("mid_req", 32'(sdram_req), 32'd1);
      chk("mid_addr", 32'(sdram_addr), 32'h100040);
      ack = 1'b1; cyc();
      obj_addr = 18'h21; rdy = 1'b1; din = 32'h11111111; cyc(); #1;
      chk("mid_obj_ok", 32'(obj_ok), 32'd0);
      chk("mid_idle_req", 32'(sdram_req), 32'd0);
      cyc(); #1;
      chk("mid_new_req", 32'(sdram_req), 32'd1);
      chk("mid_new_addr", 32'(sdram_addr), 32'h100042);
      obj_addr = 18'h20; #1;
      chk("mid_old_tag_ok", 32'(obj_ok), 32'd1);
      chk("mid_old_tag_data", obj_data, 32'h11111111);

      // reset while waiting; a late rdy must not fill anything
      do_reset();
      obj_cs = 1'b1; obj_addr = 18'h30;
      cyc(); ack = 1'b1; cyc();
      rst = 1'b1; obj_cs = 1'b0; cyc();
      rst = 1'b0; #1;
      chk("rstw_req", 32'(sdram_req), 32'd0);
      chk("rstw_obj_ok", 32'(obj_ok), 32'd0);
      rdy = 1'b1; din = 32'h77777777; cyc();
      obj_cs = 1'b1; scr_cs = 1'b1; scr_addr = 18'h0; #1;
      chk("stray_obj_ok", 32'(obj_ok), 32'd0);
      chk("stray_scr_ok", 32'(scr_ok), 32'd0);

      // three scr misses, then read statistics
      do_reset();
      scr_cs = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         scr_addr = 18'(i);
         cyc();
         ack = 1'b1; rdy = 1'b1; din = 32'(i);
         cyc();
      end
      scr_cs = 1'b0;
      for (int d = 0; d < 4; d++) begin
         debug_bus = 8'(d);
         cyc(); #1;
`ifdef JTKIWI_ARB_STATS_EN
         e_st = (d == 0) ? 8'd3 : 8'd0;
`else
         e_st = 8'd0;
`endif
         chk($sformatf("stats_sel%0d", d), 32'(st_dout), 32'(e_st));
      end

      // random traffic against the model
      do_reset();
      mv[0] = 1'b0; mv[1] = 1'b0; mt[0] = 18'd0; mt[1] = 18'd0;
      ph = 0; mch = 1'b0; mlast = 1'b1; mtag = 18'd0; mcnt[0] = 0; mcnt[1] = 0;
      sd_lat = 22'd0;
      for (int n = 0; n < 2000; n++) begin
         if (ph == 1) sd_lat = sdram_addr;
         if ($urandom_range(0, 3) == 0) scr_cs = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) scr_addr = 18'($urandom_range(0, 5));
         if ($urandom_range(0, 3) == 0) obj_cs = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) obj_addr = 18'($urandom_range(0, 5));
         ack = 1'b0; rdy = 1'b0; din = $urandom;
         if (ph == 1) begin
            ack = ($urandom_range(0, 2) == 0);
            rdy = ack && ($urandom_range(0, 3) == 0);
         end else if (ph == 2) begin
            rdy = ($urandom_range(0, 2) == 0);
         end else begin
            rdy = ($urandom_range(0, 15) == 0);
         end
         if (rdy && ph != 0) din = mem(sd_lat);
         #1;
         e_ok0 = scr_cs && mv[0] && (mt[0] == scr_addr);
         e_ok1 = obj_cs && mv[1] && (mt[1] == obj_addr);
         chk("rnd_scr_ok", 32'(scr_ok), 32'(e_ok0));
         chk("rnd_obj_ok", 32'(obj_ok), 32'(e_ok1));
         if (e_ok0) chk("rnd_scr_data", scr_data, mem(sd(mt[0], SCR_OFF)));
         if (e_ok1) chk("rnd_obj_data", obj_data, mem(sd(mt[1], OBJ_OFF)));
         chk("rnd_req", 32'(sdram_req), 32'(ph == 1));
         if (ph == 1) chk("rnd_addr", 32'(sdram_addr), 32'(sd(mtag, mch ? OBJ_OFF : SCR_OFF)));
         m0 = scr_cs && !e_ok0;
         m1 = obj_cs && !e_ok1;
         if (ph == 0) begin
            if (m0 || m1) begin
               g     = !(m0 && (!m1 || mlast));
               mch   = g;
               mlast = g;
               mtag  = g ? obj_addr : scr_addr;
               if (mcnt[g] < 65535) mcnt[g]++;
               ph    = 1;
            end
         end else if (ph == 1) begin
            if (ack && rdy) model_fill();
            else if (ack) ph = 2;
         end else begin
            if (rdy) model_fill();
         end
         cyc();
      end
      scr_cs = 1'b0; obj_cs = 1'b0;
      for (int d = 0; d < 4; d++) begin
         debug_bus = 8'(d);
         cyc(); #1;
`ifdef JTKIWI_ARB_STATS_EN
         e_st = 8'((mcnt[d / 2] >> ((d % 2) * 8)) & 255);
`else
         e_st = 8'd0;
`endif
         chk($sformatf("rnd_stats_sel%0d", d), 32'(st_dout), 32'(e_st));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
